// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode, flag index and FSM state definitions for alu_seq_unit
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operand channel and result channel of alu_seq_unit
//   in_valid/in_ready/op_a/op_b/op_sel : operand and opcode channel
//   out_valid/out_ready/result/flags   : result channel, flags = {N, Z, C, V}
//   master drives operands and out_ready; slave is the ALU
interface alu_seq_if #(parameter int WIDTH = 4);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;

   modport master (
      output in_valid, op_a, op_b, op_sel, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op_a, op_b, op_sel, out_ready,
      output in_ready, out_valid, result, flags
   );

endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational ADD/SUB/AND/OR/XOR with NZCV flags
//   a, b  : operands
//   op    : opcode; any non single-cycle opcode yields y=0, flags=4'b0101
//   y     : result
//   flags : {N, Z, C, V}
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_e          op,
   output logic [WIDTH-1:0] y,
   output logic [3:0]       flags
);

   logic             sub, arith, logic_op;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   sum;

   assign sub      = op == ALU_SUB;
   assign arith    = op == ALU_ADD || sub;
   assign logic_op = op inside {ALU_AND, ALU_OR, ALU_XOR};
   // SUB is A + ~B + 1, so the carry out is the "no borrow" flag
   assign bx  = sub ? ~b : b;
   assign sum = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
   assign y   = arith ? sum[WIDTH-1:0] :
                op == ALU_AND ? a & b :
                op == ALU_OR  ? a | b :
                op == ALU_XOR ? a ^ b : '0;

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = y[WIDTH-1];
      flags[FLAG_Z] = y == '0;
      flags[FLAG_C] = arith & sum[WIDTH];
      // V doubles as the error marker for opcodes this core cannot execute
      flags[FLAG_V] = arith ? (a[WIDTH-1] == bx[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]) : !logic_op;
   end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU, single-cycle arithmetic/logic, one-bit-per-cycle shifts
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_if slave (operand channel in, result/flags channel out)
//   ALU_SEQ_SRA_EN : when defined, op_sel=7 is an iterative arithmetic shift right;
//                    otherwise op_sel=7 is illegal and returns 0 with flags 4'b0101
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);

   localparam int SHAMT_W = $clog2(WIDTH) + 1;

   state_e               state, state_n;
   alu_op_e              op_in, op_r;
   logic [WIDTH-1:0]     wr, core_y, step_y, res_r;
   logic [SHAMT_W-1:0]   cnt;
   logic [3:0]           core_f, flg_r;
   logic                 accept, is_shift, step_c;

   assign op_in = alu_op_e'(bus.op_sel);
`ifdef ALU_SEQ_SRA_EN
   assign is_shift = op_in inside {ALU_SLL, ALU_SRL, ALU_SRA};
`else
   assign is_shift = op_in inside {ALU_SLL, ALU_SRL};
`endif

   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.result    = res_r;
   assign bus.flags     = flg_r;
   assign accept        = bus.in_valid && bus.in_ready;

   alu_seq_core #(.WIDTH(WIDTH)) core (
      .a     (bus.op_a),
      .b     (bus.op_b),
      .op    (op_in),
      .y     (core_y),
      .flags (core_f)
   );

   // one shift step; SRA only reaches here when the feature is enabled
   assign step_y = op_r == ALU_SLL ? {wr[WIDTH-2:0], 1'b0} : {op_r == ALU_SRA && wr[WIDTH-1], wr[WIDTH-1:1]};
   assign step_c = op_r == ALU_SLL ? wr[WIDTH-1] : wr[0];

   always_comb begin
      state_n = state;
      if (accept)
         state_n = (is_shift && bus.op_b != '0) ? SHIFT : DONE;
      if (state == SHIFT && cnt == SHAMT_W'(1))
         state_n = DONE;
      if (state == DONE && bus.out_ready)
         state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r  <= ALU_ADD;
         wr    <= '0;
         cnt   <= '0;
         res_r <= '0;
         flg_r <= '0;
      end else if (accept) begin
         op_r  <= op_in;
         wr    <= bus.op_a;
         // shifts of WIDTH or more behave exactly like a WIDTH-step shift
         cnt   <= (bus.op_b >= WIDTH'(WIDTH)) ? SHAMT_W'(WIDTH) : SHAMT_W'(bus.op_b);
         // a shift by 0 finishes here with the operand unchanged and C=V=0
         res_r <= is_shift ? bus.op_a : core_y;
         flg_r <= is_shift ? {bus.op_a[WIDTH-1], bus.op_a == '0, 2'b00} : core_f;
      end else if (state == SHIFT) begin
         wr  <= step_y;
         cnt <= cnt - SHAMT_W'(1);
         if (cnt == SHAMT_W'(1)) begin
            res_r <= step_y;
            flg_r <= {step_y[WIDTH-1], step_y == '0, step_c, 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed and randomized checks of alu_seq_unit against an arithmetic reference model
module tb_alu_seq_unit;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_pass = 0;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // reference: result, flags {N,Z,C,V} and cycles from accept edge to out_valid
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                 output logic [W-1:0] r, output logic [3:0] f, output int lat);
      int   k, sa, sb, s;
      logic c, v;
      k   = (int'(b) >= W) ? W : int'(b);
      sa  = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb  = b[W-1] ? int'(b) - (1 << W) : int'(b);
      c   = 1'b0;
      v   = 1'b0;
      lat = 1;
      r   = '0;
      case (op)
         3'd0: begin s = int'(a) + int'(b); r = s[W-1:0]; c = s >= (1 << W);
                     v = (sa + sb > (1 << (W-1)) - 1) || (sa + sb < -(1 << (W-1))); end
         3'd1: begin s = int'(a) - int'(b); r = s[W-1:0]; c = a >= b;
                     v = (sa - sb > (1 << (W-1)) - 1) || (sa - sb < -(1 << (W-1))); end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         3'd5: begin r = (k >= W) ? '0 : a << k; c = (k == 0) ? 1'b0 : a[W-k]; lat = 1 + k; end
         3'd6: begin r = a >> k; c = (k == 0) ? 1'b0 : a[k-1]; lat = 1 + k; end
         default: begin
`ifdef ALU_SEQ_SRA_EN
            r = $signed(a) >>> k; c = (k == 0) ? 1'b0 : a[k-1]; lat = 1 + k;
`endif
         end
      endcase
      f = {r[W-1], r == '0, c, v};
`ifndef ALU_SEQ_SRA_EN
      if (op == 3'd7) f = 4'b0101;
`endif
   endfunction

   // one complete transaction, entered and left at #1 after a rising edge with the unit idle
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input int hold);
      logic [W-1:0] er;
      logic [3:0]   ef;
      int           el, cyc;
      model(a, b, op, er, ef, el);
      check("in_ready_idle", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      bus.op_sel   = op;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.op_a     = W'($urandom);
      bus.op_b     = W'($urandom);
      bus.op_sel   = 3'($urandom);
      cyc = 1;
      while (!bus.out_valid && cyc < 24) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("latency op%0d a%0h b%0h", op, a, b), cyc, el);
      check($sformatf("result op%0d a%0h b%0h", op, a, b), bus.result, er);
      check($sformatf("flags op%0d a%0h b%0h", op, a, b), bus.flags, ef);
      check("in_ready_busy", bus.in_ready, 0);
      repeat (hold) begin @(posedge clk); #1; end
      if (hold > 0) begin
         check("hold_valid", bus.out_valid, 1);
         check("hold_result", bus.result, er);
         check("hold_flags", bus.flags, ef);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("out_valid_clear", bus.out_valid, 0);
   endtask

   initial begin
      logic [W-1:0] a, b;
      logic [2:0]   op;
      int           seen;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.op_sel    = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_flags", bus.flags, 0);
      check("rst_in_ready", bus.in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      do_op(4'h7, 4'h9, 3'd0, 0);
      do_op(4'h3, 4'h5, 3'd1, 1);
      do_op(4'h8, 4'h1, 3'd1, 0);
      do_op(4'b0011, 4'd2, 3'd5, 2);
      do_op(4'b1001, 4'd9, 3'd6, 0);
      do_op(4'b1000, 4'd1, 3'd7, 0);
      do_op(4'b1011, 4'd0, 3'd6, 0);
      do_op(4'b0101, 4'd4, 3'd5, 0);

      // backpressure: result held while a second operand waits on in_valid
      bus.in_valid = 1'b1; bus.op_a = 4'h1; bus.op_b = 4'h1; bus.op_sel = 3'd0;
      @(posedge clk); #1;
      bus.op_a = 4'h3; bus.op_b = 4'h4;
      check("bp_valid", bus.out_valid, 1);
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_result", bus.result, 4'h2);
         check("bp_flags", bus.flags, 4'b0000);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("bp_released_valid", bus.out_valid, 0);
      check("bp_released_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp_second_valid", bus.out_valid, 1);
      check("bp_second_result", bus.result, 4'h7);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // reset in the middle of a shift
      bus.in_valid = 1'b1; bus.op_a = 4'b0011; bus.op_b = 4'd3; bus.op_sel = 3'd5;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_valid", bus.out_valid, 0);
      check("midrst_result", bus.result, 0);
      check("midrst_flags", bus.flags, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen++;
      end
      check("midrst_no_stale", seen, 0);
      check("midrst_ready_after", bus.in_ready, 1);

      for (int i = 0; i < 150; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = W'($urandom);
         b  = (op >= 3'd5 && $urandom_range(0, 1) == 1) ? W'($urandom_range(0, W)) : W'($urandom);
         do_op(a, b, op, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
